alu_op_sequencer: RTL

//  Upstream control/register stage for the 8-bit ALU (ALU_sel/load_shift/cout/zout interface).

---
 rtl/alu_op_sequencer_pkg.sv | 52 +++++
 rtl/alu_op_sequencer_if.sv | 40 ++++
 rtl/alu_op_sequencer_decode.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, ALU select and load/shift
// encodings (common with the ALU itself), FSM states and the decoded-operation record.
package alu_op_sequencer_pkg;

    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_CNT_W = 3;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOR  = 3'b011,
        OP_SHR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_CLR  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        SEL_LDSH = 2'b00,
        SEL_NOR  = 2'b01,
        SEL_ADD  = 2'b10,
        SEL_SUB  = 2'b11
    } alu_sel_e;

    typedef enum logic [1:0] {
        LS_ZERO = 2'b00,
        LS_SHL  = 2'b01,
        LS_PASS = 2'b10,
        LS_SHR  = 2'b11
    } load_shift_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        alu_sel_e               sel;
        load_shift_e            ls;
        logic                   a_from_data;
        logic                   is_nop;
        logic [SEQ_CNT_W-1:0]   iter;
    } decode_t;

    // A zero shift amount still costs one harmless pass so that every op writes once.
    function automatic logic [SEQ_CNT_W-1:0] shiftPasses(input logic [SEQ_CNT_W-1:0] count);
        return (count == '0) ? SEQ_CNT_W'(1) : count;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the instruction handshake, the ALU drive/return lines and the
// accumulator status seen by the sequencer's neighbours.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [WIDTH-1:0]  op_data;
    logic [CNT_W-1:0]  op_count;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [1:0]        alu_sel;
    logic [1:0]        alu_load_shift;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_cout;
    logic              alu_zout;

    logic [WIDTH-1:0]  acc;
    logic              c_flag;
    logic              z_flag;
    logic              busy;
    logic              done;

    modport master (
        output op_valid, op_code, op_data, op_count,
        output alu_result, alu_cout, alu_zout,
        input  op_ready, alu_a, alu_b, alu_sel, alu_load_shift,
        input  acc, c_flag, z_flag, busy, done
    );

    modport slave (
        input  op_valid, op_code, op_data, op_count,
        input  alu_result, alu_cout, alu_zout,
        output op_ready, alu_a, alu_b, alu_sel, alu_load_shift,
        output acc, c_flag, z_flag, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode decoder: maps an incoming op to ALU select, load/shift
// control, number of ALU passes and the a-operand source.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [2:0]            op_code_i,
    input  logic [SEQ_CNT_W-1:0]  op_count_i,
    output decode_t               dec_o
);

    always_comb begin
        dec_o.sel         = SEL_LDSH;
        dec_o.ls          = LS_PASS;
        dec_o.a_from_data = 1'b0;
        dec_o.is_nop      = 1'b0;
        dec_o.iter        = SEQ_CNT_W'(1);

        case (opcode_e'(op_code_i))
            OP_LOAD: begin
                dec_o.a_from_data = 1'b1;
            end
            OP_ADD: begin
                dec_o.sel = SEL_ADD;
            end
            OP_SUB: begin
                dec_o.sel = SEL_SUB;
            end
            OP_NOR: begin
                dec_o.sel = SEL_NOR;
            end
            OP_SHR: begin
                dec_o.ls   = (op_count_i == '0) ? LS_PASS : LS_SHR;
                dec_o.iter = shiftPasses(op_count_i);
            end
            OP_SHL: begin
                dec_o.ls   = (op_count_i == '0) ? LS_PASS : LS_SHL;
                dec_o.iter = shiftPasses(op_count_i);
            end
            OP_CLR: begin
                dec_o.ls = LS_ZERO;
            end
            OP_NOP: begin
                dec_o.is_nop = 1'b1;
                dec_o.iter   = '0;
            end
            default: begin
                dec_o.is_nop = 1'b1;
                dec_o.iter   = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control/register stage in front of the 8-bit ALU: accepts one op per handshake,
// steers the ALU for one or more passes and writes the result into acc/C/Z.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    alu_op_sequencer_if.slave bus
);

    state_e                  state_q;
    decode_t                 dec_q;
    logic [SEQ_WIDTH-1:0]    data_q;
    logic [SEQ_CNT_W-1:0]    rem_q;
    logic [SEQ_WIDTH-1:0]    acc_q;
    logic                    c_q;
    logic                    z_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;

    decode_t                 dec;

    alu_op_decode u_decode (
        .op_code_i  (bus.op_code),
        .op_count_i (bus.op_count),
        .dec_o      (dec)
    );

    // Outside EXEC the ALU is parked on a pass of acc with a zero b operand.
    always_comb begin
        bus.alu_a          = acc_q;
        bus.alu_b          = '0;
        bus.alu_sel        = SEL_LDSH;
        bus.alu_load_shift = LS_PASS;
        if (state_q == ST_EXEC) begin
            bus.alu_a          = dec_q.a_from_data ? data_q : acc_q;
            bus.alu_b          = data_q;
            bus.alu_sel        = dec_q.sel;
            bus.alu_load_shift = dec_q.ls;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dec_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        data_q  <= bus.op_data;
                        dec_q   <= dec;
                        rem_q   <= dec.iter;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (dec.is_nop) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    acc_q <= bus.alu_result;
                    c_q   <= bus.alu_cout;
                    z_q   <= bus.alu_zout;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == SEQ_CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.op_ready = ready_q;
    assign bus.acc      = acc_q;
    assign bus.c_flag   = c_q;
    assign bus.z_flag   = z_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
